// File: rtl/acumulador_credito_pkg.sv
// Shared definitions for the credit accumulator: FSM state encoding,
// legal banknote values and default sizing.
package acumulador_credito_pkg;

    // Default width of the credit and change registers.
    localparam int CREDIT_W_DEF   = 10;
    // Default ceiling on accumulated credit, in reais.
    localparam int MAX_CREDIT_DEF = 500;

    // FSM state encoding.
    localparam logic [1:0] ST_OCIOSO     = 2'd0;  // no credit held
    localparam logic [1:0] ST_ACUMULANDO = 2'd1;  // credit > 0
    localparam logic [1:0] ST_VENDA      = 2'd2;  // one-cycle transit after a sale with change
    localparam logic [1:0] ST_DEVOLVE    = 2'd3;  // change presented, waiting for dispenser ack

    // Note values produced by the upstream banknote decoder.
    localparam logic [7:0] NOTA_2   = 8'd2;
    localparam logic [7:0] NOTA_5   = 8'd5;
    localparam logic [7:0] NOTA_10  = 8'd10;
    localparam logic [7:0] NOTA_20  = 8'd20;
    localparam logic [7:0] NOTA_50  = 8'd50;
    localparam logic [7:0] NOTA_100 = 8'd100;
    localparam logic [7:0] NOTA_200 = 8'd200;

endpackage

// File: rtl/acumulador_credito.sv
// Running credit accumulator for the vending path: adds decoded notes,
// settles purchases or cancels, and presents change to the dispenser
// with a valid/ack handshake. Every output comes straight from a flop.
module acumulador_credito
    import acumulador_credito_pkg::*;
#(
    parameter int CREDIT_W   = CREDIT_W_DEF,
    parameter int MAX_CREDIT = MAX_CREDIT_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                nota_valida,
    input  logic [7:0]          valor_nota,
    input  logic                comprar,
    input  logic [7:0]          preco,
    input  logic                cancelar,
    input  logic                troco_ack,
    output logic [CREDIT_W-1:0] credito,
    output logic [CREDIT_W-1:0] troco,
    output logic                troco_valido,
    output logic                venda_ok,
    output logic                saldo_insuficiente,
    output logic                nota_rejeitada,
    output logic                ocupado
);

    // Ceiling expressed at the widened sum width so the compare never wraps.
    localparam logic [CREDIT_W:0] MAX_SOMA = (CREDIT_W+1)'(MAX_CREDIT);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credito_q, credito_d;
    logic [CREDIT_W-1:0] troco_q, troco_d;
    logic                troco_valido_q, troco_valido_d;
    logic                venda_ok_q, venda_ok_d;
    logic                saldo_insuf_q, saldo_insuf_d;
    logic                nota_rej_q, nota_rej_d;
    logic                ocupado_q, ocupado_d;

    logic [CREDIT_W:0]   soma;
    logic [CREDIT_W-1:0] preco_ext;
    logic [CREDIT_W-1:0] diferenca;

    assign soma      = {1'b0, credito_q} + (CREDIT_W+1)'(valor_nota);
    assign preco_ext = CREDIT_W'(preco);
    assign diferenca = credito_q - preco_ext;

    // Next-state and response decode; strobe priority is cancelar > comprar > nota_valida.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        credito_d      = credito_q;
        troco_d        = troco_q;
        troco_valido_d = troco_valido_q;
        venda_ok_d     = 1'b0;
        saldo_insuf_d  = 1'b0;
        nota_rej_d     = 1'b0;

        case (state_q)
            ST_OCIOSO, ST_ACUMULANDO: begin
                if (cancelar) begin
                    // A note arriving alongside a cancel is refused, even if there is nothing to refund.
                    nota_rej_d = nota_valida;
                    if (credito_q != '0) begin
                        troco_d        = credito_q;
                        credito_d      = '0;
                        troco_valido_d = 1'b1;
                        state_d        = ST_DEVOLVE;
                    end
                end else if (comprar) begin
                    nota_rej_d = nota_valida;
                    if (preco != '0 && credito_q >= preco_ext) begin
                        venda_ok_d = 1'b1;
                        troco_d    = diferenca;
                        credito_d  = '0;
                        // Exact payment skips the change handshake entirely.
                        state_d    = (diferenca != '0) ? ST_VENDA : ST_OCIOSO;
                    end else begin
                        saldo_insuf_d = 1'b1;
                    end
                end else if (nota_valida && valor_nota != '0) begin
                    if (soma > MAX_SOMA) begin
                        nota_rej_d = 1'b1;
                    end else begin
                        credito_d = soma[CREDIT_W-1:0];
                        state_d   = ST_ACUMULANDO;
                    end
                end
            end

            ST_VENDA: begin
                nota_rej_d     = nota_valida;
                troco_valido_d = 1'b1;
                state_d        = ST_DEVOLVE;
            end

            ST_DEVOLVE: begin
                nota_rej_d = nota_valida;
                if (troco_ack && troco_valido_q) begin
                    troco_valido_d = 1'b0;
                    troco_d        = '0;
                    state_d        = ST_OCIOSO;
                end
            end

            default: begin
                state_d = ST_OCIOSO;
            end
        endcase

        ocupado_d = (state_d == ST_VENDA) || (state_d == ST_DEVOLVE);
    end

    // State and output registers; reset discards any pending change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_OCIOSO;
            credito_q      <= '0;
            troco_q        <= '0;
            troco_valido_q <= 1'b0;
            venda_ok_q     <= 1'b0;
            saldo_insuf_q  <= 1'b0;
            nota_rej_q     <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q        <= state_d;
            credito_q      <= credito_d;
            troco_q        <= troco_d;
            troco_valido_q <= troco_valido_d;
            venda_ok_q     <= venda_ok_d;
            saldo_insuf_q  <= saldo_insuf_d;
            nota_rej_q     <= nota_rej_d;
            ocupado_q      <= ocupado_d;
        end
    end

    assign credito            = credito_q;
    assign troco              = troco_q;
    assign troco_valido       = troco_valido_q;
    assign venda_ok           = venda_ok_q;
    assign saldo_insuficiente = saldo_insuf_q;
    assign nota_rejeitada     = nota_rej_q;
    assign ocupado            = ocupado_q;

endmodule

// File: tb/tb_acumulador_credito.sv
// Self-checking bench for acumulador_credito: a table of per-cycle stimulus
// with expected registered outputs, routed through a scoreboard queue, plus
// hand-written reset sequences.
module tb_acumulador_credito;
    import acumulador_credito_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       nota_valida;
    logic [7:0] valor_nota;
    logic       comprar;
    logic [7:0] preco;
    logic       cancelar;
    logic       troco_ack;
    logic [9:0] credito;
    logic [9:0] troco;
    logic       troco_valido;
    logic       venda_ok;
    logic       saldo_insuficiente;
    logic       nota_rejeitada;
    logic       ocupado;

    acumulador_credito #(.CREDIT_W(CREDIT_W_DEF), .MAX_CREDIT(MAX_CREDIT_DEF)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .nota_valida        (nota_valida),
        .valor_nota         (valor_nota),
        .comprar            (comprar),
        .preco              (preco),
        .cancelar           (cancelar),
        .troco_ack          (troco_ack),
        .credito            (credito),
        .troco              (troco),
        .troco_valido       (troco_valido),
        .venda_ok           (venda_ok),
        .saldo_insuficiente (saldo_insuficiente),
        .nota_rejeitada     (nota_rejeitada),
        .ocupado            (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [9:0] cred;
        logic [9:0] troco;
        logic       tv;
        logic       vok;
        logic       sal;
        logic       rej;
        logic       ocup;
    } out_t;

    typedef struct packed {
        logic       nv;
        logic [7:0] valor;
        logic       cmp;
        logic [7:0] preco;
        logic       cnc;
        logic       ack;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t v(input int nv, input int valor, input int cmp, input int pr,
                               input int cnc, input int ack, input int cred, input int tr,
                               input int tv, input int vok, input int sal, input int rej,
                               input int ocup);
        vec_t r;
        r.nv         = 1'(nv);
        r.valor      = 8'(valor);
        r.cmp        = 1'(cmp);
        r.preco      = 8'(pr);
        r.cnc        = 1'(cnc);
        r.ack        = 1'(ack);
        r.exp.cred   = 10'(cred);
        r.exp.troco  = 10'(tr);
        r.exp.tv     = 1'(tv);
        r.exp.vok    = 1'(vok);
        r.exp.sal    = 1'(sal);
        r.exp.rej    = 1'(rej);
        r.exp.ocup   = 1'(ocup);
        return r;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.cred  = credito;
        o.troco = troco;
        o.tv    = troco_valido;
        o.vok   = venda_ok;
        o.sal   = saldo_insuficiente;
        o.rej   = nota_rejeitada;
        o.ocup  = ocupado;
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cred=%0d troco=%0d tv=%b vok=%b sal=%b rej=%b ocup=%b, expected cred=%0d troco=%0d tv=%b vok=%b sal=%b rej=%b ocup=%b",
                     name, got.cred, got.troco, got.tv, got.vok, got.sal, got.rej, got.ocup,
                     exp.cred, exp.troco, exp.tv, exp.vok, exp.sal, exp.rej, exp.ocup);
        end
    endtask

    task automatic idle_inputs();
        nota_valida = 1'b0;
        valor_nota  = 8'd0;
        comprar     = 1'b0;
        preco       = 8'd0;
        cancelar    = 1'b0;
        troco_ack   = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string name, input vec_t x);
        out_t e;
        @(negedge clock);
        nota_valida = x.nv;
        valor_nota  = x.valor;
        comprar     = x.cmp;
        preco       = x.preco;
        cancelar    = x.cnc;
        troco_ack   = x.ack;
        exp_q.push_back(x.exp);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check(name, sample(), e);
        idle_inputs();
    endtask

    out_t zeros;

    initial begin
        zeros = '0;
        idle_inputs();
        reset_n = 1'b0;
        #12;
        check("reset_state", sample(), zeros);
        @(negedge clock);
        reset_n = 1'b1;

        //           nv valor        cmp preco cnc ack | cred troco tv vok sal rej ocup
        vecs.push_back(v(1, NOTA_2,   0, 0,   0, 0,   2,   0,   0, 0, 0, 0, 0));
        vecs.push_back(v(1, NOTA_5,   0, 0,   0, 0,   7,   0,   0, 0, 0, 0, 0));
        vecs.push_back(v(1, NOTA_10,  0, 0,   0, 0,   17,  0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,        1, 12,  0, 0,   0,   5,   0, 1, 0, 0, 1));  // sale, VENDA
        vecs.push_back(v(0, 0,        0, 0,   0, 0,   0,   5,   1, 0, 0, 0, 1));  // DEVOLVE
        vecs.push_back(v(0, 0,        0, 0,   0, 0,   0,   5,   1, 0, 0, 0, 1));  // held
        vecs.push_back(v(0, 0,        0, 0,   0, 1,   0,   0,   0, 0, 0, 0, 0));  // ack
        vecs.push_back(v(1, NOTA_10,  0, 0,   0, 0,   10,  0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,        1, 10,  0, 0,   0,   0,   0, 1, 0, 0, 0));  // exact price
        vecs.push_back(v(0, 0,        1, 0,   0, 0,   0,   0,   0, 0, 1, 0, 0));  // price 0
        vecs.push_back(v(1, NOTA_200, 0, 0,   0, 0,   200, 0,   0, 0, 0, 0, 0));
        vecs.push_back(v(1, NOTA_200, 0, 0,   0, 0,   400, 0,   0, 0, 0, 0, 0));
        vecs.push_back(v(1, NOTA_200, 0, 0,   0, 0,   400, 0,   0, 0, 0, 1, 0));  // would be 600
        vecs.push_back(v(1, NOTA_100, 0, 0,   0, 0,   500, 0,   0, 0, 0, 0, 0));  // exactly max
        vecs.push_back(v(1, NOTA_2,   0, 0,   0, 0,   500, 0,   0, 0, 0, 1, 0));  // 502
        vecs.push_back(v(0, 0,        1, 250, 0, 0,   0,   250, 0, 1, 0, 0, 1));
        vecs.push_back(v(0, 0,        0, 0,   0, 1,   0,   250, 1, 0, 0, 0, 1));  // ack in VENDA ignored
        vecs.push_back(v(0, 0,        0, 0,   0, 1,   0,   0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,        0, 0,   0, 1,   0,   0,   0, 0, 0, 0, 0));  // stray ack
        vecs.push_back(v(0, 0,        0, 0,   1, 0,   0,   0,   0, 0, 0, 0, 0));  // cancel, no credit
        vecs.push_back(v(1, 0,        0, 0,   0, 0,   0,   0,   0, 0, 0, 0, 0));  // zero note
        vecs.push_back(v(1, NOTA_50,  0, 0,   0, 0,   50,  0,   0, 0, 0, 0, 0));
        vecs.push_back(v(1, NOTA_10,  1, 20,  1, 0,   0,   50,  1, 0, 0, 1, 1));  // all three strobes
        vecs.push_back(v(1, NOTA_5,   0, 0,   0, 0,   0,   50,  1, 0, 0, 1, 1));  // note while busy
        vecs.push_back(v(0, 0,        1, 20,  0, 0,   0,   50,  1, 0, 0, 0, 1));  // buy while busy
        vecs.push_back(v(0, 0,        0, 0,   0, 1,   0,   0,   0, 0, 0, 0, 0));
        vecs.push_back(v(1, NOTA_20,  0, 0,   0, 0,   20,  0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,        1, 30,  0, 0,   20,  0,   0, 0, 1, 0, 0));  // short credit
        vecs.push_back(v(1, NOTA_5,   1, 100, 0, 0,   20,  0,   0, 0, 1, 1, 0));  // note with buy
        vecs.push_back(v(0, 0,        0, 0,   1, 0,   0,   20,  1, 0, 0, 0, 1));  // refund 20

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of a cycle while change is pending.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_devolve", sample(), zeros);
        @(negedge clock);
        reset_n = 1'b1;
        apply("post_reset_note", v(1, NOTA_5, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
        apply("post_reset_ack",  v(0, 0,      0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acumulador_credito.md
Name: acumulador_credito

Overview:
- Downstream stage of the banknote-value decoder: consumes the 8-bit note value it produces and keeps the customer's running credit.
- Accepts a purchase request against a product price, or a cancel.
- Computes the change (troco) and holds it with a valid/ack handshake until the dispenser takes it.
- Sits between note decoding and the change-dispensing/vending control logic.

Parameters:
- CREDIT_W, 10, width of credit and change registers (bits).
- MAX_CREDIT, 500, maximum credit accepted; a note that would exceed it is rejected.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- nota_valida  input  1  one-cycle strobe; valor_nota is valid this cycle.
- valor_nota  input  8  note value in reais (0,2,5,10,20,50,100,200).
- comprar  input  1  one-cycle purchase request.
- preco  input  8  product price in reais; sampled only in the cycle comprar is high.
- cancelar  input  1  one-cycle cancel/refund request.
- troco_ack  input  1  dispenser has taken troco.
- credito  output  CREDIT_W  current accumulated credit.
- troco  output  CREDIT_W  change amount; meaningful while troco_valido=1.
- troco_valido  output  1  change pending; held until troco_ack.
- venda_ok  output  1  one-cycle pulse: purchase accepted.
- saldo_insuficiente  output  1  one-cycle pulse: comprar with credito<preco or preco=0.
- nota_rejeitada  output  1  one-cycle pulse: note refused (overflow or busy).
- ocupado  output  1  high in VENDA and DEVOLVE states.

Behaviour:
- Reset (async, reset_n=0): state=OCIOSO; all outputs 0.
- All outputs are registered. Responses appear on the first rising edge after the strobe (1-cycle latency).
- FSM states: OCIOSO (credit=0), ACUMULANDO (credit>0), VENDA, DEVOLVE.
- Priority when strobes coincide in the same cycle: cancelar > comprar > nota_valida. Lower-priority strobes that cycle are ignored, with no pulse. Exception: nota_valida is rejected (nota_rejeitada=1) if accompanied by cancelar or comprar.
- Note acceptance, in OCIOSO or ACUMULANDO:
  - valor_nota=0: ignored, no pulse.
  - credito+valor_nota > MAX_CREDIT: nota_rejeitada=1, credit unchanged.
  - Otherwise credito += valor_nota and state becomes ACUMULANDO.
  - Sum is computed at CREDIT_W+1 bits so it never wraps.
- comprar, in OCIOSO or ACUMULANDO:
  - If preco!=0 and credito>=preco: venda_ok=1, troco<=credito-preco, credito<=0.
    - troco>0: go to VENDA for one cycle, then DEVOLVE.
    - troco=0: go directly to OCIOSO.
  - Else: saldo_insuficiente=1, credit and state unchanged.
- cancelar, in OCIOSO or ACUMULANDO:
  - credito>0: troco<=credito, credito<=0, go to DEVOLVE.
  - credito=0: no effect.
- VENDA: one-cycle transit state; sets troco_valido=1 and moves to DEVOLVE.
- DEVOLVE:
  - troco_valido=1 and troco held stable.
  - On troco_ack=1: troco_valido<=0, troco<=0, go to OCIOSO.
  - troco_ack while troco_valido=0 is ignored in every state.
- Busy (VENDA/DEVOLVE): nota_valida gives nota_rejeitada=1. comprar and cancelar are ignored. ocupado=1.
- Reset mid-operation: pending change is discarded and credit cleared. Recording that loss is the system controller's responsibility.

Decomposition:
- Shared package: state encoding (OCIOSO, ACUMULANDO, VENDA, DEVOLVE), note-value constants, MAX_CREDIT default.
- No sub-module needed. Optionally factor the saturating-add/compare into acum_somador as a combinational helper.

Test Plan:
- Reset, then notes 2,5,10 (one strobe each) -> credito=2, 7, 17 on successive cycles; state=ACUMULANDO.
- credito=17, comprar with preco=12 -> venda_ok pulse, credito=0; after the VENDA cycle troco_valido=1, troco=5. Hold until troco_ack -> troco_valido=0, state=OCIOSO.
- credito=10, comprar with preco=10 -> venda_ok=1, troco_valido stays 0, state=OCIOSO. comprar with preco=0 -> saldo_insuficiente=1.
- credito=400, note 200 -> nota_rejeitada=1, credito stays 400. Then note 100 -> credito=500.
- credito=50, cancelar and comprar(preco=20) and nota_valida(10) in the same cycle -> troco=50, nota_rejeitada=1, venda_ok=0. In DEVOLVE, nota_valida(5) -> nota_rejeitada=1.
- credito=20 in DEVOLVE with troco_valido=1, assert reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately, state=OCIOSO.
